pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameters: WAIT_MAX, default 15, maximum consecutive data-memory wait cycles before halt; CNT_W, default 32, performance counter width.
REQ-002 SHALL have ports, one per line, as name  direction  width  meaning:
clk  in  1  sole clock, rising edge.
rst  in  1  synchronous, active-high reset.
id_rs1_ad, id_rs2_ad  in  5  source registers of the instruction in ID.
ex_rs1_ad, ex_rs2_ad  in  5  source registers of the instruction in EX.
ex_rd_ad  in  5  destination register in EX.
ex_DMread  in  1  the instruction in EX is a load.
mem_rd_ad, mem_rdEn  in  5/1  destination and write enable in MEM.
wb_rd_ad, wb_rdEn  in  5/1  destination and write enable in WB.
branch_taken  in  1  a redirect has resolved in EX.
dm_req, dm_ready  in  1/1  MEM-stage data-memory access and completion.
pc_en  out  1  PC update enable.
pip_en_if_id, pip_en_id_ex, pip_en_ex_mem, pip_en_mem_wb  out  1 each  stage-register enables.
discard_if_id, discard_id_ex, discard_ex_mem, discard_mem_wb  out  1 each  stage-register bubble inserts.
fwd_a, fwd_b  out  2  ALU operand source: 00 = register file, 01 = MEM, 10 = WB.
halted  out  1  sticky memory-timeout halt.
stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-003 SHALL implement FSM states RUN, MEM_WAIT and HALT.
REQ-004 In RUN with dm_req=1 and dm_ready=0, SHALL in the same cycle drive pc_en=0 and all pip_en=0 except pip_en_mem_wb=1 with discard_mem_wb=1, and go to MEM_WAIT.
REQ-005 In MEM_WAIT, SHALL hold the REQ-004 pattern and increment wait_cnt each cycle.
REQ-006 MEM_WAIT SHALL return to RUN on the cycle dm_ready=1; that cycle SHALL drive the normal RUN outputs; wait_cnt SHALL clear.
REQ-007 MEM_WAIT SHALL go to HALT when wait_cnt reaches WAIT_MAX with dm_ready=0.
REQ-008 HALT SHALL drive pc_en=0, all pip_en=0 and halted=1 until rst.
REQ-009 In RUN, branch_taken=1 SHALL drive discard_if_id=1 and discard_id_ex=1 with all pip_en=1 and pc_en=1, so that two bubbles are inserted.
REQ-010 In RUN, a load-use hazard SHALL drive pc_en=0, pip_en_if_id=0 and discard_id_ex=1, with the other pip_en=1, for exactly one cycle.
REQ-011 A load-use hazard SHALL be ex_DMread=1, ex_rd_ad!=0 and ex_rd_ad equal to id_rs1_ad or id_rs2_ad.
REQ-012 Priority SHALL be HALT > MEM_WAIT > branch_taken > load-use; a branch held during MEM_WAIT SHALL be acted on in the first RUN cycle.
REQ-013 fwd_a/fwd_b SHALL be combinational; MEM match (mem_rdEn, mem_rd_ad!=0, equal to ex_rs1_ad/ex_rs2_ad) SHALL yield 01; else WB match SHALL yield 10; else 00. MEM SHALL win when both match.
REQ-014 In RUN with no event, SHALL drive all pip_en=1, all discard=0 and pc_en=1.

Reset
REQ-015 While rst=1, SHALL drive all pip_en=1, all discard=1 and pc_en=0, clearing the unreset stage registers.
REQ-016 rst SHALL force state to RUN and clear wait_cnt, halted, stall_cnt and flush_cnt, including mid-MEM_WAIT and in HALT.

Configuration
REQ-017 With PIPELINE_CTRL_PERF_EN defined, stall_cnt SHALL increment on each cycle with pc_en=0 outside reset.
REQ-018 With PIPELINE_CTRL_PERF_EN defined, flush_cnt SHALL increment on each branch flush, and both counters SHALL saturate at all-ones.
REQ-019 Without PIPELINE_CTRL_PERF_EN, stall_cnt and flush_cnt SHALL be constant 0 and no counter flops SHALL be inferred.

Structure
REQ-020 The FSM state encoding and the FWD_RF=00, FWD_MEM=01, FWD_WB=10 constants SHALL live in shared package pipeline_ctrl_pkg.
REQ-021 Forwarding comparison SHALL be a sub-module, pip_fwd_unit, instantiated once per operand.

Verification
REQ-022 Load x5, then the next instruction reads x5 -> one cycle with pc_en=0 and discard_id_ex=1, then fwd_a=10 on the consumer.
REQ-023 Load to x0, then the next instruction reads x0 -> no stall, fwd_a=00.
REQ-024 branch_taken pulse in RUN -> discard_if_id=discard_id_ex=1 for one cycle, flush_cnt increments by 1.
REQ-025 dm_req=1 with dm_ready low 3 cycles -> 3 frozen cycles, RUN on cycle 4, stall_cnt=3.
REQ-026 dm_ready low 16 cycles with WAIT_MAX=15 -> halted=1 held; rst pulse -> RUN, halted=0, counters 0.
REQ-027 MEM and WB both write x7, EX reads x7 on rs2 -> fwd_b=01.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  localparam int unsigned RegAdW = 5;
  typedef logic [RegAdW-1:0] reg_ad_t;

  // Controller FSM encoding.
  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StHalt    = 2'd2
  } state_e;

  // ALU operand source select.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // True when a writing stage targets a non-zero register that a reader uses.
  function automatic logic rd_hit(input logic en, input reg_ad_t rd, input reg_ad_t rs);
    return en && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/control bundle between the pipeline datapath (master) and the
// controller (slave). Signal names follow the datapath's own naming.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic [4:0]       id_rs1_ad;
  logic [4:0]       id_rs2_ad;
  logic [4:0]       ex_rs1_ad;
  logic [4:0]       ex_rs2_ad;
  logic [4:0]       ex_rd_ad;
  logic             ex_DMread;
  logic [4:0]       mem_rd_ad;
  logic             mem_rdEn;
  logic [4:0]       wb_rd_ad;
  logic             wb_rdEn;
  logic             branch_taken;
  logic             dm_req;
  logic             dm_ready;

  logic             pc_en;
  logic             pip_en_if_id;
  logic             pip_en_id_ex;
  logic             pip_en_ex_mem;
  logic             pip_en_mem_wb;
  logic             discard_if_id;
  logic             discard_id_ex;
  logic             discard_ex_mem;
  logic             discard_mem_wb;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1_ad, id_rs2_ad, ex_rs1_ad, ex_rs2_ad, ex_rd_ad, ex_DMread,
    output mem_rd_ad, mem_rdEn, wb_rd_ad, wb_rdEn, branch_taken, dm_req, dm_ready,
    input  pc_en, pip_en_if_id, pip_en_id_ex, pip_en_ex_mem, pip_en_mem_wb,
    input  discard_if_id, discard_id_ex, discard_ex_mem, discard_mem_wb,
    input  fwd_a, fwd_b, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1_ad, id_rs2_ad, ex_rs1_ad, ex_rs2_ad, ex_rd_ad, ex_DMread,
    input  mem_rd_ad, mem_rdEn, wb_rd_ad, wb_rdEn, branch_taken, dm_req, dm_ready,
    output pc_en, pip_en_if_id, pip_en_id_ex, pip_en_ex_mem, pip_en_mem_wb,
    output discard_if_id, discard_id_ex, discard_ex_mem, discard_mem_wb,
    output fwd_a, fwd_b, halted, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Per-operand forwarding select: the younger MEM result beats the WB result.
module pip_fwd_unit
  import pipeline_ctrl_pkg::*;
(
  input  reg_ad_t    i_src_ad,
  input  reg_ad_t    i_mem_rd_ad,
  input  logic       i_mem_rd_en,
  input  reg_ad_t    i_wb_rd_ad,
  input  logic       i_wb_rd_en,
  output logic [1:0] o_fwd
);

  // Pick the newest in-flight producer of the operand.
  always_comb begin
    o_fwd = FWD_RF;
    if (rd_hit(i_mem_rd_en, i_mem_rd_ad, i_src_ad)) begin
      o_fwd = FWD_MEM;
    end else if (rd_hit(i_wb_rd_en, i_wb_rd_ad, i_src_ad)) begin
      o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait freeze with timeout halt,
// branch flush, load-use stall and operand forwarding.
// Build option: define PIPELINE_CTRL_PERF_EN to enable the saturating
// stall/flush performance counters; otherwise they read as constant zero.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);

  localparam int unsigned WaitW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WaitW-1:0] WaitMaxW = WaitW'(WAIT_MAX);

  state_e           r_state;
  logic [WaitW-1:0] r_wait_cnt;
  logic             r_halted;

  logic       w_load_use;
  logic       w_mem_stall;
  logic       w_run_cycle;
  logic       w_branch_flush;
  logic       w_pc_en;
  // Stage order in both vectors: {if_id, id_ex, ex_mem, mem_wb}.
  logic [3:0] w_pip_en;
  logic [3:0] w_discard;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // Hazard detection and event priority (halt > memory wait > branch > load-use).
  always_comb begin
    w_load_use = rd_hit(bus.ex_DMread, bus.ex_rd_ad, bus.id_rs1_ad) ||
                 rd_hit(bus.ex_DMread, bus.ex_rd_ad, bus.id_rs2_ad);
    w_mem_stall = 1'b0;
    unique case (r_state)
      StRun:     w_mem_stall = bus.dm_req && !bus.dm_ready;
      StMemWait: w_mem_stall = !bus.dm_ready;
      default:   w_mem_stall = 1'b0;
    endcase
    // The dm_ready cycle of a wait decodes exactly like a plain RUN cycle.
    w_run_cycle    = !rst && (r_state != StHalt) && !w_mem_stall;
    w_branch_flush = w_run_cycle && bus.branch_taken;
  end

  // Stage enables, bubble inserts and PC enable.
  always_comb begin
    w_pc_en   = 1'b1;
    w_pip_en  = 4'b1111;
    w_discard = 4'b0000;
    if (rst) begin
      // Clock bubbles through every stage so unreset stage registers clear.
      w_pc_en   = 1'b0;
      w_pip_en  = 4'b1111;
      w_discard = 4'b1111;
    end else if (r_state == StHalt) begin
      w_pc_en   = 1'b0;
      w_pip_en  = 4'b0000;
    end else if (w_mem_stall) begin
      // Freeze everything upstream of MEM; WB receives bubbles.
      w_pc_en   = 1'b0;
      w_pip_en  = 4'b0001;
      w_discard = 4'b0001;
    end else if (w_branch_flush) begin
      w_discard = 4'b1100;
    end else if (w_load_use) begin
      w_pc_en   = 1'b0;
      w_pip_en  = 4'b0111;
      w_discard = 4'b0100;
    end
  end

  // Controller FSM with the sticky halt flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StRun;
      r_wait_cnt <= '0;
      r_halted   <= 1'b0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (bus.dm_req && !bus.dm_ready) begin
            r_state    <= StMemWait;
            // The entry cycle already counts as one wait cycle.
            r_wait_cnt <= WaitW'(1);
          end
        end
        StMemWait: begin
          if (bus.dm_ready) begin
            r_state    <= StRun;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt >= WaitMaxW) begin
            r_state    <= StHalt;
            r_wait_cnt <= '0;
            r_halted   <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        StHalt: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state    <= StRun;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  pip_fwd_unit u_fwd_a (
    .i_src_ad    (bus.ex_rs1_ad),
    .i_mem_rd_ad (bus.mem_rd_ad),
    .i_mem_rd_en (bus.mem_rdEn),
    .i_wb_rd_ad  (bus.wb_rd_ad),
    .i_wb_rd_en  (bus.wb_rdEn),
    .o_fwd       (w_fwd_a)
  );

  pip_fwd_unit u_fwd_b (
    .i_src_ad    (bus.ex_rs2_ad),
    .i_mem_rd_ad (bus.mem_rd_ad),
    .i_mem_rd_en (bus.mem_rdEn),
    .i_wb_rd_ad  (bus.wb_rd_ad),
    .i_wb_rd_en  (bus.wb_rdEn),
    .o_fwd       (w_fwd_b)
  );

`ifdef PIPELINE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating stall/flush event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_en && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_branch_flush && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

  assign bus.pc_en          = w_pc_en;
  assign bus.pip_en_if_id   = w_pip_en[3];
  assign bus.pip_en_id_ex   = w_pip_en[2];
  assign bus.pip_en_ex_mem  = w_pip_en[1];
  assign bus.pip_en_mem_wb  = w_pip_en[0];
  assign bus.discard_if_id  = w_discard[3];
  assign bus.discard_id_ex  = w_discard[2];
  assign bus.discard_ex_mem = w_discard[1];
  assign bus.discard_mem_wb = w_discard[0];
  assign bus.fwd_a          = w_fwd_a;
  assign bus.fwd_b          = w_fwd_b;
  assign bus.halted         = r_halted;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes expected responses from
// a cycle-level behavioural model; a negedge monitor pops and compares.
module tb_pipeline_ctrl;

  localparam int unsigned WAIT_MAX = 15;
  localparam int unsigned CNT_W    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic       ex_ld;
    logic [4:0] mem_rd;
    logic       mem_en;
    logic [4:0] wb_rd;
    logic       wb_en;
    logic       br, req, rdy;
  } stim_t;

  typedef struct packed {
    logic             pc_en;
    logic [3:0]       pip;  // {if_id, id_ex, ex_mem, mem_wb}
    logic [3:0]       dis;
    logic [1:0]       fa, fb;
    logic             halted;
    logic [CNT_W-1:0] sc, fc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model state: how long memory has been stalling, halt flag, event totals.
  int     m_wait_len = 0;
  bit     m_halted   = 1'b0;
  longint m_stalls   = 0;
  longint m_flushes  = 0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cycle, act, req_v);
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat(input longint v);
    longint mx;
    mx = (longint'(1) << CNT_W) - 1;
    return (v > mx) ? mx[CNT_W-1:0] : v[CNT_W-1:0];
  endfunction

  // Newest writer of a non-zero register wins; x0 is never forwarded.
  function automatic logic [1:0] fwd_ref(input stim_t s, input logic [4:0] rs);
    if (s.mem_en && s.mem_rd != 0 && s.mem_rd == rs) return 2'd1;
    if (s.wb_en && s.wb_rd != 0 && s.wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_step(input stim_t s, output exp_t e);
    bit mem_busy;
    bit load_use;
    e.halted = m_halted;
`ifdef PIPELINE_CTRL_PERF_EN
    e.sc = sat(m_stalls);
    e.fc = sat(m_flushes);
`else
    e.sc = '0;
    e.fc = '0;
`endif
    e.fa = fwd_ref(s, s.ex_rs1);
    e.fb = fwd_ref(s, s.ex_rs2);
    load_use = s.ex_ld && s.ex_rd != 0 && (s.ex_rd == s.id_rs1 || s.ex_rd == s.id_rs2);
    // Once waiting, only dm_ready ends the wait.
    mem_busy = (m_wait_len > 0) ? !s.rdy : (s.req && !s.rdy);
    if (s.rst) begin
      {e.pc_en, e.pip, e.dis} = {1'b0, 4'hF, 4'hF};
      m_wait_len = 0;
      m_halted   = 1'b0;
      m_stalls   = 0;
      m_flushes  = 0;
    end else if (m_halted) begin
      {e.pc_en, e.pip, e.dis} = {1'b0, 4'h0, 4'h0};
      m_stalls++;
    end else if (mem_busy) begin
      {e.pc_en, e.pip, e.dis} = {1'b0, 4'b0001, 4'b0001};
      m_stalls++;
      m_wait_len++;
      if (m_wait_len > WAIT_MAX) m_halted = 1'b1;
    end else begin
      m_wait_len = 0;
      if (s.br) begin
        {e.pc_en, e.pip, e.dis} = {1'b1, 4'hF, 4'b1100};
        m_flushes++;
      end else if (load_use) begin
        {e.pc_en, e.pip, e.dis} = {1'b0, 4'b0111, 4'b0100};
        m_stalls++;
      end else begin
        {e.pc_en, e.pip, e.dis} = {1'b1, 4'hF, 4'h0};
      end
    end
  endtask

  task automatic cyc(input stim_t s);
    exp_t e;
    rst              = s.rst;
    bus.id_rs1_ad    = s.id_rs1;
    bus.id_rs2_ad    = s.id_rs2;
    bus.ex_rs1_ad    = s.ex_rs1;
    bus.ex_rs2_ad    = s.ex_rs2;
    bus.ex_rd_ad     = s.ex_rd;
    bus.ex_DMread    = s.ex_ld;
    bus.mem_rd_ad    = s.mem_rd;
    bus.mem_rdEn     = s.mem_en;
    bus.wb_rd_ad     = s.wb_rd;
    bus.wb_rdEn      = s.wb_en;
    bus.branch_taken = s.br;
    bus.dm_req       = s.req;
    bus.dm_ready     = s.rdy;
    model_step(s, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rdy = 1'b1;
    return s;
  endfunction

  function automatic stim_t rnd(input int unsigned rdy_pct, input int unsigned rst_pct);
    stim_t s;
    s.rst    = ($urandom_range(0, 99) < rst_pct);
    s.id_rs1 = 5'($urandom_range(0, 3));
    s.id_rs2 = 5'($urandom_range(0, 3));
    s.ex_rs1 = 5'($urandom_range(0, 3));
    s.ex_rs2 = 5'($urandom_range(0, 3));
    s.ex_rd  = 5'($urandom_range(0, 3));
    s.ex_ld  = 1'($urandom_range(0, 1));
    s.mem_rd = 5'($urandom_range(0, 3));
    s.mem_en = 1'($urandom_range(0, 1));
    s.wb_rd  = 5'($urandom_range(0, 3));
    s.wb_en  = 1'($urandom_range(0, 1));
    s.br     = ($urandom_range(0, 5) == 0);
    s.req    = ($urandom_range(0, 2) == 0);
    s.rdy    = ($urandom_range(0, 99) < rdy_pct);
    return s;
  endfunction

  // Monitor: every cycle the DUT presents one response; compare away from posedge.
  exp_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      chk("pc_en", 64'(bus.pc_en), 64'(mon_e.pc_en));
      chk("pip_en", 64'({bus.pip_en_if_id, bus.pip_en_id_ex, bus.pip_en_ex_mem,
                         bus.pip_en_mem_wb}), 64'(mon_e.pip));
      chk("discard", 64'({bus.discard_if_id, bus.discard_id_ex, bus.discard_ex_mem,
                          bus.discard_mem_wb}), 64'(mon_e.dis));
      chk("fwd_a", 64'(bus.fwd_a), 64'(mon_e.fa));
      chk("fwd_b", 64'(bus.fwd_b), 64'(mon_e.fb));
      chk("halted", 64'(bus.halted), 64'(mon_e.halted));
      chk("stall_cnt", 64'(bus.stall_cnt), 64'(mon_e.sc));
      chk("flush_cnt", 64'(bus.flush_cnt), 64'(mon_e.fc));
    end
    cycle++;
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    rst = 1'b1;
    bus.id_rs1_ad = '0; bus.id_rs2_ad = '0; bus.ex_rs1_ad = '0; bus.ex_rs2_ad = '0;
    bus.ex_rd_ad = '0; bus.ex_DMread = 1'b0; bus.mem_rd_ad = '0; bus.mem_rdEn = 1'b0;
    bus.wb_rd_ad = '0; bus.wb_rdEn = 1'b0; bus.branch_taken = 1'b0;
    bus.dm_req = 1'b0; bus.dm_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc(s);
    cyc(s);
    repeat (2) cyc(idle());

    // Load x5 followed by a reader of x5: one stall, then WB forwarding.
    s = idle(); s.ex_ld = 1; s.ex_rd = 5; s.id_rs1 = 5; cyc(s);
    s = idle(); s.mem_en = 1; s.mem_rd = 5; s.id_rs1 = 5; cyc(s);
    s = idle(); s.wb_en = 1; s.wb_rd = 5; s.ex_rs1 = 5; cyc(s);

    // Load to x0 is never a hazard and never forwarded.
    s = idle(); s.ex_ld = 1; s.ex_rd = 0; s.id_rs1 = 0; cyc(s);
    s = idle(); s.mem_en = 1; s.mem_rd = 0; s.ex_rs1 = 0; cyc(s);

    // Branch pulse, then branch colliding with a load-use hazard.
    s = idle(); s.br = 1; cyc(s);
    s = idle(); s.br = 1; s.ex_ld = 1; s.ex_rd = 3; s.id_rs2 = 3; cyc(s);
    cyc(idle());

    // Memory wait of three cycles, released on the fourth.
    s = idle(); s.req = 1; s.rdy = 0;
    repeat (3) cyc(s);
    s.rdy = 1; cyc(s);

    // MEM and WB both write x7, EX reads x7 on rs2.
    s = idle(); s.mem_en = 1; s.mem_rd = 7; s.wb_en = 1; s.wb_rd = 7; s.ex_rs2 = 7; cyc(s);

    // Branch held through a memory wait is taken in the first RUN cycle.
    s = idle(); s.req = 1; s.rdy = 0; s.br = 1;
    repeat (2) cyc(s);
    s.rdy = 1; cyc(s);

    // Exactly WAIT_MAX low cycles then ready: no halt.
    s = idle(); s.req = 1; s.rdy = 0;
    repeat (WAIT_MAX) cyc(s);
    s.rdy = 1; cyc(s);

    // One more low cycle than allowed: sticky halt until reset.
    s = idle(); s.req = 1; s.rdy = 0;
    repeat (WAIT_MAX + 1) cyc(s);
    s = idle(); s.br = 1; s.req = 1; cyc(s);
    repeat (3) cyc(idle());
    s = idle(); s.rst = 1; cyc(s);
    repeat (2) cyc(idle());

    // Reset taken in the middle of a memory wait.
    s = idle(); s.req = 1; s.rdy = 0;
    repeat (4) cyc(s);
    s = idle(); s.rst = 1; cyc(s);
    cyc(idle());

    // Random traffic: mostly-ready memory, then a slow memory that can time out.
    repeat (300) cyc(rnd(60, 1));
    repeat (200) cyc(rnd(6, 3));

    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
